// File: rtl/cdb_broadcaster_if.sv
// Bus bundle for cdb_broadcaster: FU result inputs, per-FU ready, and the registered CDB lanes.
interface cdb_broadcaster_if #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned WAYS   = 3,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PRF_W  = 6
);
  localparam int unsigned CNT_W = $clog2(WAYS) + 1;

  logic [NUM_FU-1:0]       fu_valid;
  logic [NUM_FU*XLEN-1:0]  fu_data;
  logic [NUM_FU*PRF_W-1:0] fu_prf_idx;
  logic [NUM_FU-1:0]       fu_ready;
  logic [WAYS*XLEN-1:0]    CDB_Data;
  logic [WAYS*PRF_W-1:0]   CDB_PRF_idx;
  logic [WAYS-1:0]         CDB_valid;
  logic [CNT_W-1:0]        cdb_count;

  modport master (
    output fu_valid, fu_data, fu_prf_idx,
    input  fu_ready, CDB_Data, CDB_PRF_idx, CDB_valid, cdb_count
  );

  modport slave (
    input  fu_valid, fu_data, fu_prf_idx,
    output fu_ready, CDB_Data, CDB_PRF_idx, CDB_valid, cdb_count
  );
endinterface

// File: rtl/cdb_broadcaster.sv
// Per-FU 2-entry result FIFOs drained onto a WAYS-lane, LSB-packed CDB under round-robin priority.
// Optional CDB_BYPASS_EN: a push into an empty FIFO may be broadcast in the same cycle.
module cdb_broadcaster #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned WAYS   = 3,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PRF_W  = 6
) (
  input logic               i_clock,
  input logic               i_reset,
  cdb_broadcaster_if.slave  bus
);
  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned CNT_W = $clog2(WAYS) + 1;

  logic [1:0]       r_count [NUM_FU];
  logic [NUM_FU-1:0] r_head;
  logic [NUM_FU-1:0] r_tail;
  logic [XLEN-1:0]  r_data  [NUM_FU][2];
  logic [PRF_W-1:0] r_idx   [NUM_FU][2];
  logic [PTR_W-1:0] r_rr_ptr;

  logic [WAYS*XLEN-1:0]  r_cdb_data;
  logic [WAYS*PRF_W-1:0] r_cdb_idx;
  logic [WAYS-1:0]       r_cdb_valid;
  logic [CNT_W-1:0]      r_cdb_count;

  logic [NUM_FU-1:0] w_ready;
  logic [NUM_FU-1:0] w_push;
  logic [NUM_FU-1:0] w_bypass;
  logic [NUM_FU-1:0] w_elig;
  logic [XLEN-1:0]   w_head_data [NUM_FU];
  logic [PRF_W-1:0]  w_head_idx  [NUM_FU];

  logic [NUM_FU-1:0]     w_grant;
  logic [WAYS*XLEN-1:0]  w_lane_data;
  logic [WAYS*PRF_W-1:0] w_lane_idx;
  logic [WAYS-1:0]       w_lane_valid;
  logic [CNT_W-1:0]      w_lane_count;
  logic [PTR_W-1:0]      w_nxt_rr;

  // Per-FU ready, push and the candidate entry offered to the selector
  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    assign w_ready[g] = (r_count[g] != 2'd2) & ~i_reset;
    assign w_push[g]  = bus.fu_valid[g] & w_ready[g];
`ifdef CDB_BYPASS_EN
    assign w_bypass[g] = w_push[g] & (r_count[g] == 2'd0);
`else
    assign w_bypass[g] = 1'b0;
`endif
    assign w_elig[g]      = (r_count[g] != 2'd0) | w_bypass[g];
    assign w_head_data[g] = w_bypass[g] ? bus.fu_data[g*XLEN +: XLEN]
                                        : r_data[g][r_head[g]];
    assign w_head_idx[g]  = w_bypass[g] ? bus.fu_prf_idx[g*PRF_W +: PRF_W]
                                        : r_idx[g][r_head[g]];
  end

  // Round-robin scan from r_rr_ptr; the k-th granted slot lands on lane k
  always_comb begin
    int lanes;
    int slot;
    w_grant      = '0;
    w_lane_data  = '0;
    w_lane_idx   = '0;
    w_lane_valid = '0;
    w_nxt_rr     = r_rr_ptr;
    lanes        = 0;
    slot         = 0;
    for (int k = 0; k < int'(NUM_FU); k++) begin
      slot = (int'(r_rr_ptr) + k) % int'(NUM_FU);
      for (int j = 0; j < int'(NUM_FU); j++) begin
        if ((j == slot) && w_elig[j] && (lanes < int'(WAYS))) begin
          for (int l = 0; l < int'(WAYS); l++) begin
            if (l == lanes) begin
              w_lane_data[l*XLEN +: XLEN]   = w_head_data[j];
              w_lane_idx[l*PRF_W +: PRF_W]  = w_head_idx[j];
              w_lane_valid[l]               = 1'b1;
            end
          end
          w_grant[j] = 1'b1;
          w_nxt_rr   = PTR_W'((j + 1) % int'(NUM_FU));
          lanes      = lanes + 1;
        end
      end
    end
    w_lane_count = CNT_W'(lanes);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < int'(NUM_FU); i++) begin
        r_count[i] <= 2'd0;
      end
      r_head      <= '0;
      r_tail      <= '0;
      r_rr_ptr    <= '0;
      r_cdb_data  <= '0;
      r_cdb_idx   <= '0;
      r_cdb_valid <= '0;
      r_cdb_count <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_FU); i++) begin
        // A bypassed entry goes straight to the CDB and never occupies the FIFO
        if (!(w_grant[i] && w_bypass[i])) begin
          if (w_push[i]) begin
            r_data[i][r_tail[i]] <= bus.fu_data[i*XLEN +: XLEN];
            r_idx[i][r_tail[i]]  <= bus.fu_prf_idx[i*PRF_W +: PRF_W];
            r_tail[i]            <= ~r_tail[i];
          end
          if (w_grant[i]) begin
            r_head[i] <= ~r_head[i];
          end
          r_count[i] <= r_count[i] + 2'(w_push[i]) - 2'(w_grant[i]);
        end
      end
      r_rr_ptr    <= w_nxt_rr;
      r_cdb_data  <= w_lane_data;
      r_cdb_idx   <= w_lane_idx;
      r_cdb_valid <= w_lane_valid;
      r_cdb_count <= w_lane_count;
    end
  end

  assign bus.fu_ready    = w_ready;
  assign bus.CDB_Data    = r_cdb_data;
  assign bus.CDB_PRF_idx = r_cdb_idx;
  assign bus.CDB_valid   = r_cdb_valid;
  assign bus.cdb_count   = r_cdb_count;
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster (NUM_FU=4, WAYS=3): vector table plus stress/reset/fairness sequences.
module tb_cdb_broadcaster;
  localparam int unsigned NUM_FU = 4;
  localparam int unsigned WAYS   = 3;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned PRF_W  = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_broadcaster_if #(.NUM_FU(NUM_FU), .WAYS(WAYS), .XLEN(XLEN), .PRF_W(PRF_W)) bus ();

  cdb_broadcaster #(.NUM_FU(NUM_FU), .WAYS(WAYS), .XLEN(XLEN), .PRF_W(PRF_W)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [23:0] ix;    // {fu3,fu2,fu1,fu0} pushed tags
    logic [3:0]  erdy;
    logic [2:0]  ev;
    logic [1:0]  ecnt;
    logic [17:0] eix;   // {lane2,lane1,lane0} expected tags
  } vec_t;

  vec_t vecs [17];

  logic [7:0]  seq [4];
  logic [31:0] sb  [4][$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dat(input logic [5:0] ix);
    return (ix == 6'd5) ? 32'hDEAD_BEEF : (32'hA000_0000 | 32'(ix));
  endfunction

  task automatic drive_idle();
    bus.fu_valid   = '0;
    bus.fu_data    = '0;
    bus.fu_prf_idx = '0;
  endtask

  // Monitor one visible CDB cycle against the per-FU scoreboard queues
  task automatic monitor(input bit fair, input logic [3:0] act, inout int miss [4]);
    logic [2:0]  v;
    logic [31:0] d;
    logic [31:0] e;
    logic [1:0]  f;
    logic [3:0]  seen;
    v    = bus.CDB_valid;
    seen = '0;
    chk("lsb_packed", 128'(v == 3'b000 || v == 3'b001 || v == 3'b011 || v == 3'b111), 128'(1));
    chk("cdb_count", 128'(bus.cdb_count), 128'($countones(v)));
    for (int l = 0; l < 3; l++) begin
      d = bus.CDB_Data[l*32 +: 32];
      if (v[l]) begin
        f = d[17:16];
        seen[f] = 1'b1;
        if (sb[f].size() == 0) begin
          chk("unexpected_result", 128'(d), 128'(0));
        end else begin
          e = sb[f].pop_front();
          chk("lane_data", 128'(d), 128'(e));
          chk("lane_idx", 128'(bus.CDB_PRF_idx[l*6 +: 6]), 128'({e[17:16], e[3:0]}));
        end
      end else begin
        chk("idle_lane", 128'({bus.CDB_Data[l*32 +: 32], bus.CDB_PRF_idx[l*6 +: 6]}), 128'(0));
      end
    end
    if (fair) begin
      for (int i = 0; i < 4; i++) begin
        if (act[i]) begin
          if (seen[i]) miss[i] = 0;
          else         miss[i] = miss[i] + 1;
          chk($sformatf("fair_fu%0d", i), 128'(miss[i] < 2), 128'(1));
        end
      end
    end
  endtask

  // FUs in act present results every cycle, holding each until accepted, then drain
  task automatic stress(input logic [3:0] act, input int ncyc, input bit fair, input bit want_drop);
    int         miss [4];
    int         first_drop;
    logic [3:0] acc;
    first_drop = -1;
    for (int i = 0; i < 4; i++) miss[i] = 0;
    for (int c = 0; c < ncyc + 8; c++) begin
      bus.fu_valid = (c < ncyc) ? act : 4'b0000;
      for (int i = 0; i < 4; i++) begin
        bus.fu_data[i*32 +: 32]  = {8'hC0, 6'h00, 2'(i), 8'h00, seq[i]};
        bus.fu_prf_idx[i*6 +: 6] = {2'(i), seq[i][3:0]};
      end
      @(negedge clk);
      acc = bus.fu_valid & bus.fu_ready;
      if (first_drop < 0 && c < ncyc && ((bus.fu_ready & act) != act)) first_drop = c;
      monitor(fair && c >= 4 && c < ncyc, act, miss);
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          sb[i].push_back(bus.fu_data[i*32 +: 32]);
          seq[i] = seq[i] + 8'd1;
        end
      end
      @(posedge clk);
      #1;
    end
    if (want_drop) chk("ready_drop_within_8", 128'(first_drop >= 0 && first_drop <= 8), 128'(1));
    for (int i = 0; i < 4; i++) chk($sformatf("drained_fu%0d", i), 128'(sb[i].size()), 128'(0));
    drive_idle();
  endtask

  initial begin
    logic [31:0] edat;
    bit          found;

    // rst, v, pushed tags, exp ready, exp valid, exp count, exp lane tags
    vecs[0]  = '{1'b0, 4'b0100, {6'd0, 6'd5, 6'd0, 6'd0},     4'b1111, 3'b000, 2'd0, {6'd0, 6'd0, 6'd0}};
    vecs[1]  = '{1'b0, 4'b0000, 24'd0,                         4'b1111, 3'b000, 2'd0, {6'd0, 6'd0, 6'd0}};
    vecs[2]  = '{1'b0, 4'b0000, 24'd0,                         4'b1111, 3'b001, 2'd1, {6'd0, 6'd0, 6'd5}};
    vecs[3]  = '{1'b1, 4'b0000, 24'd0,                         4'b0000, 3'b000, 2'd0, {6'd0, 6'd0, 6'd0}};
    vecs[4]  = '{1'b0, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1},     4'b1111, 3'b000, 2'd0, {6'd0, 6'd0, 6'd0}};
    vecs[5]  = '{1'b0, 4'b0000, 24'd0,                         4'b1111, 3'b000, 2'd0, {6'd0, 6'd0, 6'd0}};
    vecs[6]  = '{1'b0, 4'b0000, 24'd0,                         4'b1111, 3'b111, 2'd3, {6'd3, 6'd2, 6'd1}};
    vecs[7]  = '{1'b0, 4'b0000, 24'd0,                         4'b1111, 3'b001, 2'd1, {6'd0, 6'd0, 6'd4}};
    vecs[8]  = '{1'b0, 4'b1001, {6'd13, 6'd0, 6'd0, 6'd10},   4'b1111, 3'b000, 2'd0, {6'd0, 6'd0, 6'd0}};
    vecs[9]  = '{1'b0, 4'b0000, 24'd0,                         4'b1111, 3'b000, 2'd0, {6'd0, 6'd0, 6'd0}};
    vecs[10] = '{1'b0, 4'b0000, 24'd0,                         4'b1111, 3'b011, 2'd2, {6'd0, 6'd13, 6'd10}};
    vecs[11] = '{1'b0, 4'b1111, {6'd24, 6'd23, 6'd22, 6'd21}, 4'b1111, 3'b000, 2'd0, {6'd0, 6'd0, 6'd0}};
    vecs[12] = '{1'b0, 4'b1111, {6'd34, 6'd33, 6'd32, 6'd31}, 4'b1111, 3'b000, 2'd0, {6'd0, 6'd0, 6'd0}};
    vecs[13] = '{1'b0, 4'b1000, {6'd40, 6'd0, 6'd0, 6'd0},    4'b0111, 3'b111, 2'd3, {6'd23, 6'd22, 6'd21}};
    vecs[14] = '{1'b0, 4'b0000, 24'd0,                         4'b1111, 3'b111, 2'd3, {6'd32, 6'd31, 6'd24}};
    vecs[15] = '{1'b0, 4'b0000, 24'd0,                         4'b1111, 3'b011, 2'd2, {6'd0, 6'd34, 6'd33}};
    vecs[16] = '{1'b0, 4'b0000, 24'd0,                         4'b1111, 3'b000, 2'd0, {6'd0, 6'd0, 6'd0}};

    for (int i = 0; i < 4; i++) seq[i] = 8'd0;
    rst = 1'b1;
    drive_idle();

    // Two reset cycles; outputs cleared and ready held low
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 128'(bus.CDB_valid), 128'(0));
    chk("rst_count", 128'(bus.cdb_count), 128'(0));
    chk("rst_data", 128'(bus.CDB_Data), 128'(0));
    chk("rst_ready", 128'(bus.fu_ready), 128'(0));
    @(posedge clk);
    #1;

    for (int n = 0; n < 17; n++) begin
      rst          = vecs[n].rst;
      bus.fu_valid = vecs[n].v;
      for (int i = 0; i < 4; i++) begin
        bus.fu_prf_idx[i*6 +: 6] = vecs[n].ix[i*6 +: 6];
        bus.fu_data[i*32 +: 32]  = dat(vecs[n].ix[i*6 +: 6]);
      end
      @(negedge clk);
      chk($sformatf("v%0d_ready", n), 128'(bus.fu_ready), 128'(vecs[n].erdy));
      chk($sformatf("v%0d_valid", n), 128'(bus.CDB_valid), 128'(vecs[n].ev));
      chk($sformatf("v%0d_count", n), 128'(bus.cdb_count), 128'(vecs[n].ecnt));
      chk($sformatf("v%0d_idx", n), 128'(bus.CDB_PRF_idx), 128'(vecs[n].eix));
      for (int l = 0; l < 3; l++) begin
        edat = vecs[n].ev[l] ? dat(vecs[n].eix[l*6 +: 6]) : 32'h0;
        chk($sformatf("v%0d_data%0d", n, l), 128'(bus.CDB_Data[l*32 +: 32]), 128'(edat));
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    drive_idle();

    // Saturating traffic from all FUs, scoreboarded per FU
    stress(4'b1111, 20, 1'b0, 1'b1);

    // Back-pressure then mid-operation reset: nothing buffered may reach the CDB
    bus.fu_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      bus.fu_data[i*32 +: 32]  = 32'hBAD0_0000 | 32'(i);
      bus.fu_prf_idx[i*6 +: 6] = 6'h3C | 6'(i);
    end
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (bus.fu_ready != 4'b1111) found = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("backpressure_seen", 128'(found), 128'(1));
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 128'(bus.CDB_valid), 128'(0));
    chk("post_rst_count", 128'(bus.cdb_count), 128'(0));
    chk("post_rst_data", 128'(bus.CDB_Data), 128'(0));
    chk("post_rst_ready", 128'(bus.fu_ready), 128'(4'b1111));
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("no_stale_result", 128'({bus.CDB_valid, bus.CDB_PRF_idx}), 128'(0));
    end
    @(posedge clk);
    #1;

    // Fairness: two FUs under capacity, then all four saturating
    stress(4'b1001, 16, 1'b1, 1'b0);
    stress(4'b1111, 16, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
